fetch_sequencer: RTL and testbench

Instruction-fetch control stage for each core. It sits directly upstream of the 16-bit PC register (register_type_1) and drives that register's inc_en and write_en. It reads the PC value, issues a read to instruction memory, captures the returned word into an instruction latch, and hands it to decode with a valid/ready handshake. It also loads branch targets into the PC and detects memory timeouts.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_sequencer_if.sv | 70 +++++++
 rtl/fetch_timeout_cnt.sv | 42 ++++
 rtl/fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - default data/address widths
//   - FSM state encoding (3-bit constants, kept as plain localparams so the
//     encoding is visible on the debug port and in older tool flows)
//   - small helper used to decode the busy indication from a state value
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_VALID  = 3'd3;
    localparam logic [2:0] ST_BRANCH = 3'd4;

    // Any state other than IDLE means a fetch sequence is in progress.
    function automatic logic state_is_busy(input logic [2:0] st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Bus bundle between the fetch sequencer, instruction memory and decode.
//
// Memory side:
//   mem_addr      instruction address (sequencer -> memory)
//   mem_rd_req    read request level, held until mem_rd_ack
//   mem_rd_ack    read data valid this cycle (memory -> sequencer)
//   mem_rd_data   read data
// Decode side:
//   instr         latched instruction word
//   instr_valid   instr is valid
//   instr_ready   decode accepts instr
//   branch_req    decode requests a branch with the accepted instruction
//   branch_target branch destination
//
// Handshake rule (decode side): a transfer happens on a rising clk edge where
// instr_valid && instr_ready are both 1. Once instr_valid is raised, it stays
// high and instr stays stable until that transfer; branch_req/branch_target
// are only meaningful in the transfer cycle. The memory side is a
// request/acknowledge level protocol: mem_rd_req stays high (mem_addr stable)
// until the cycle mem_rd_ack is high, which also carries mem_rd_data.
//
// Modports:
//   master - the fetch sequencer
//   slave  - memory + decode environment
// ---------------------------------------------------------------------------
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
);

    logic [ADDR_W_P-1:0] mem_addr;
    logic                mem_rd_req;
    logic                mem_rd_ack;
    logic [DATA_W_P-1:0] mem_rd_data;

    logic [DATA_W_P-1:0] instr;
    logic                instr_valid;
    logic                instr_ready;
    logic                branch_req;
    logic [ADDR_W_P-1:0] branch_target;

    modport master (
        output mem_addr,
        output mem_rd_req,
        input  mem_rd_ack,
        input  mem_rd_data,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  branch_req,
        input  branch_target
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_req,
        output mem_rd_ack,
        output mem_rd_data,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output branch_req,
        output branch_target
    );

endinterface

// File: rtl/fetch_timeout_cnt.sv
// ---------------------------------------------------------------------------
// fetch_timeout_cnt
// Counts cycles spent waiting for instruction memory.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   clear   synchronous clear (wins over en)
//   en      count one cycle
//   expired count has reached TIMEOUT-1
//
// TIMEOUT must be >= 2 and 2**CNT_W must exceed TIMEOUT.
// ---------------------------------------------------------------------------
module fetch_timeout_cnt #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a stray enable after expiry cannot wrap around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch control stage. Drives the PC register's increment/load
// strobes, reads the instruction at the current PC from memory, latches it
// and hands it to decode. Branch targets are loaded into the PC on the
// decode handshake; a memory read that is never acknowledged ends the fetch
// with a sticky fetch_err.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin fetching (honoured in IDLE only)
//   halt            stop after the current instruction is consumed
//   pc_in           current PC value from the PC register
//   pc_inc_en       one-cycle PC increment strobe
//   pc_write_en     one-cycle PC load strobe
//   pc_wdata        PC load value (branch target)
//   busy            sequencer not in IDLE
//   fetch_err       sticky memory timeout flag, cleared by the next start
//   state_dbg       current FSM state encoding
//   bus             memory + decode bundle (master side)
//
// All outputs come straight from flops (busy/state_dbg decode only the state
// register), so there is no input-to-output combinational path.
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt,
    input  logic [ADDR_W_P-1:0] pc_in,
    output logic                pc_inc_en,
    output logic                pc_write_en,
    output logic [ADDR_W_P-1:0] pc_wdata,
    output logic                busy,
    output logic                fetch_err,
    output logic [2:0]          state_dbg,
    fetch_sequencer_if.master   bus
);

    logic [2:0]          state;
    logic [ADDR_W_P-1:0] mem_addr_q;
    logic                mem_rd_req_q;
    logic [DATA_W_P-1:0] instr_q;
    logic                instr_valid_q;

    logic                cnt_clear;
    logic                cnt_en;
    logic                cnt_expired;
    logic                handshake;

    assign handshake = instr_valid_q && bus.instr_ready;

    // Counter restarts for every request; it only advances while an
    // unacknowledged request is outstanding.
    assign cnt_clear = (state == ST_ISSUE);
    assign cnt_en    = (state == ST_WAIT) && !bus.mem_rd_ack;

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mem_addr_q    <= '0;
            mem_rd_req_q  <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_inc_en     <= 1'b0;
            pc_write_en   <= 1'b0;
            pc_wdata      <= '0;
            fetch_err     <= 1'b0;
        end else begin
            // PC strobes are single-cycle pulses unless re-armed below.
            pc_inc_en   <= 1'b0;
            pc_write_en <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fetch_err <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    mem_addr_q   <= pc_in;
                    mem_rd_req_q <= 1'b1;
                    state        <= ST_WAIT;
                end

                ST_WAIT: begin
                    // An ack in the expiry cycle still completes the fetch.
                    if (bus.mem_rd_ack) begin
                        instr_q       <= bus.mem_rd_data;
                        mem_rd_req_q  <= 1'b0;
                        pc_inc_en     <= 1'b1;
                        instr_valid_q <= 1'b1;
                        state         <= ST_VALID;
                    end else if (cnt_expired) begin
                        mem_rd_req_q <= 1'b0;
                        fetch_err    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end

                ST_VALID: begin
                    if (handshake) begin
                        instr_valid_q <= 1'b0;
                        if (bus.branch_req) begin
                            pc_wdata    <= bus.branch_target;
                            pc_write_en <= 1'b1;
                            state       <= ST_BRANCH;
                        end else if (halt) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end

                ST_BRANCH: begin
                    // The PC register loads during this cycle, so the next
                    // ISSUE sees the branch target on pc_in.
                    if (halt) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    mem_rd_req_q  <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd_req  = mem_rd_req_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;

    assign busy      = state_is_busy(state);
    assign state_dbg = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    import fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start;
    logic        halt;
    logic [15:0] pc_in;
    logic        pc_inc_en;
    logic        pc_write_en;
    logic [15:0] pc_wdata;
    logic        busy;
    logic        fetch_err;
    logic [2:0]  state_dbg;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .DATA_W_P (16),
        .ADDR_W_P (16),
        .TIMEOUT  (4),
        .CNT_W    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .pc_in       (pc_in),
        .pc_inc_en   (pc_inc_en),
        .pc_write_en (pc_write_en),
        .pc_wdata    (pc_wdata),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .state_dbg   (state_dbg),
        .bus         (bus.master)
    );

    // ---------------- PC register model ----------------
    logic [15:0] pc_reg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pc_reg <= 16'h000A;
        else if (pc_write_en) pc_reg <= pc_wdata;
        else if (pc_inc_en)   pc_reg <= pc_reg + 16'd1;
    end
    assign pc_in = pc_reg;

    // ---------------- instruction memory responder ----------------
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h000A: return 16'h1234;
            16'h000B: return 16'h5678;
            16'h0040: return 16'h9ABC;
            16'h0041: return 16'hC0DE;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    logic ack_on;
    logic force_ack;
    logic acked;

    initial begin
        bus.mem_rd_ack  = 1'b0;
        bus.mem_rd_data = 16'h0000;
        acked = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_rd_ack = 1'b0;
            if (force_ack) begin
                bus.mem_rd_ack  = 1'b1;
                bus.mem_rd_data = 16'hDEAD;
            end else if (ack_on && bus.mem_rd_req && !acked) begin
                bus.mem_rd_ack  = 1'b1;
                bus.mem_rd_data = mem_word(bus.mem_addr);
                acked = 1'b1;
            end
            if (!bus.mem_rd_req) acked = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_instr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares memory requests and decode transfers against the
    // expected queues, sampled mid-cycle once all drivers have settled.
    logic prev_req;
    initial begin
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (bus.mem_rd_req && !prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got addr %h expected no request", bus.mem_addr);
                    end else begin
                        check("mem_addr", {16'h0, bus.mem_addr}, {16'h0, exp_addr_q.pop_front()});
                    end
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    if (exp_instr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_instr: got %h expected no transfer", bus.instr);
                    end else begin
                        check("instr_xfer", {16'h0, bus.instr}, {16'h0, exp_instr_q.pop_front()});
                    end
                end
                if (pc_inc_en || pc_write_en)
                    check("pc_strobe_excl", {31'h0, pc_inc_en & pc_write_en}, 32'h0);
            end
            prev_req = bus.mem_rd_req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req();
        int n = 0;
        while (!bus.mem_rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_rd_req) begin
            total++; bad++;
            $display("FAIL wait_req: got no mem_rd_req expected one within 20 cycles");
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: got no instr_valid expected one within 20 cycles");
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   n;
        logic seen_valid;

        start = 1'b0; halt = 1'b0;
        bus.instr_ready = 1'b0; bus.branch_req = 1'b0; bus.branch_target = 16'h0;
        ack_on = 1'b1; force_ack = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_busy",        {31'h0, busy},             32'h0);
        check("rst_req",         {31'h0, bus.mem_rd_req},   32'h0);
        check("rst_valid",       {31'h0, bus.instr_valid},  32'h0);
        check("rst_instr",       {16'h0, bus.instr},        32'h0);
        check("rst_mem_addr",    {16'h0, bus.mem_addr},     32'h0);
        check("rst_pc_wdata",    {16'h0, pc_wdata},         32'h0);
        check("rst_fetch_err",   {31'h0, fetch_err},        32'h0);
        check("rst_strobes",     {30'h0, pc_inc_en, pc_write_en}, 32'h0);
        check("rst_state",       {29'h0, state_dbg},        {29'h0, ST_IDLE});

        // basic fetch at 000A
        exp_addr_q.push_back(16'h000A);
        exp_instr_q.push_back(16'h1234);
        pulse_start();
        check("issue_busy",  {31'h0, busy},           32'h1);
        check("issue_state", {29'h0, state_dbg},      {29'h0, ST_ISSUE});
        check("issue_req",   {31'h0, bus.mem_rd_req}, 32'h0);
        @(negedge clk);
        check("wait_req",    {31'h0, bus.mem_rd_req},  32'h1);
        check("wait_valid",  {31'h0, bus.instr_valid}, 32'h0);
        check("wait_inc",    {31'h0, pc_inc_en},       32'h0);
        @(negedge clk);
        check("fetch_valid", {31'h0, bus.instr_valid}, 32'h1);
        check("fetch_inc",   {31'h0, pc_inc_en},       32'h1);
        check("fetch_instr", {16'h0, bus.instr},       32'h1234);
        check("fetch_req",   {31'h0, bus.mem_rd_req},  32'h0);
        @(negedge clk);
        check("inc_single",  {31'h0, pc_inc_en},       32'h0);

        // back-pressure
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'h0, bus.instr_valid}, 32'h1);
            check("bp_instr", {16'h0, bus.instr},       32'h1234);
            check("bp_req",   {31'h0, bus.mem_rd_req},  32'h0);
            @(negedge clk);
        end
        check("bp_pc", {16'h0, pc_in}, 32'h000B);
        exp_addr_q.push_back(16'h000B);
        exp_instr_q.push_back(16'h5678);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        check("xfer_drop_valid", {31'h0, bus.instr_valid}, 32'h0);
        wait_valid();
        check("second_instr", {16'h0, bus.instr}, 32'h5678);

        // branch on handshake
        exp_addr_q.push_back(16'h0040);
        exp_instr_q.push_back(16'h9ABC);
        bus.branch_req = 1'b1; bus.branch_target = 16'h0040; bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.branch_req = 1'b0; bus.branch_target = 16'h0000; bus.instr_ready = 1'b0;
        check("br_write_en", {31'h0, pc_write_en},  32'h1);
        check("br_wdata",    {16'h0, pc_wdata},     32'h0040);
        check("br_no_inc",   {31'h0, pc_inc_en},    32'h0);
        check("br_state",    {29'h0, state_dbg},    {29'h0, ST_BRANCH});
        @(negedge clk);
        check("br_single",   {31'h0, pc_write_en},  32'h0);
        check("br_to_issue", {29'h0, state_dbg},    {29'h0, ST_ISSUE});

        // halt raised during WAIT: fetch completes, stop on handshake
        wait_req();
        halt = 1'b1;
        wait_valid();
        check("halt_instr", {16'h0, bus.instr}, 32'h9ABC);
        check("halt_busy",  {31'h0, busy},      32'h1);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0; halt = 1'b0;
        check("halt_idle_busy",  {31'h0, busy},            32'h0);
        check("halt_idle_state", {29'h0, state_dbg},       {29'h0, ST_IDLE});
        check("halt_valid",      {31'h0, bus.instr_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_no_req", {31'h0, bus.mem_rd_req}, 32'h0);
        end

        // timeout: TIMEOUT=4, no ack
        ack_on = 1'b0;
        exp_addr_q.push_back(16'h0041);
        pulse_start();
        wait_req();
        n = 0; seen_valid = 1'b0;
        while (bus.mem_rd_req && n < 20) begin
            n++;
            if (bus.instr_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        check("to_wait_cycles", n,                        32'd4);
        check("to_fetch_err",   {31'h0, fetch_err},       32'h1);
        check("to_no_valid",    {31'h0, seen_valid | bus.instr_valid}, 32'h0);
        check("to_busy",        {31'h0, busy},            32'h0);

        // new start clears fetch_err; then async reset mid-WAIT
        exp_addr_q.push_back(16'h0041);
        pulse_start();
        check("err_cleared", {31'h0, fetch_err}, 32'h0);
        wait_req();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_req",   {31'h0, bus.mem_rd_req},  32'h0);
        check("arst_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("arst_busy",  {31'h0, busy},            32'h0);
        check("arst_state", {29'h0, state_dbg},       {29'h0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        check("spur_req",   {31'h0, bus.mem_rd_req},  32'h0);
        check("spur_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("spur_busy",  {31'h0, busy},            32'h0);
        check("spur_instr", {16'h0, bus.instr},       32'h0);

        // all expected traffic observed
        check("addr_q_empty",  exp_addr_q.size(),  32'd0);
        check("instr_q_empty", exp_instr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
